xvec2_vscale_elem_seq: RTL and testbench
========================================

XVEC2_VSCALE_ELEM_SEQ -- requirements
Module: xvec2_vscale_elem_seq

Interface
REQ-001 Parameter: NUM_ELEMS, 4, number of vector elements per register; legal values are powers of two from 2 to 8.
REQ-002 Parameter: IDX_W, 2, element index width, equal to log2(NUM_ELEMS).
REQ-003 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  reset; asynchronous and active-high.
REQ-005 Port: req_valid  input  1  a vector ALU op is offered.
REQ-006 Port: req_ready  output  1  the sequencer accepts the op this cycle.
REQ-007 Port: req_vl  input  4  requested element count.
REQ-008 Port: req_src_b_sel  input  `SRC_B_SEL_WIDTH  operand B source for all elements.
REQ-009 Port: req_rd  input  5  destination vector register.
REQ-010 Port: alu_valid  output  1  the element at alu_elem is issued to the ALU lane this cycle.
REQ-011 Port: alu_elem  output  IDX_W  index of the element being issued.
REQ-012 Port: alu_src_b_sel  output  `SRC_B_SEL_WIDTH  select driven to the src_b mux.
REQ-013 Port: alu_stall  input  1  the lane cannot take an element this cycle.
REQ-014 Port: kill  input  1  abort the in-flight op (exception or flush).
REQ-015 Port: wb_valid  output  1  single-cycle write-back strobe.
REQ-016 Port: wb_rd  output  5  write-back register.
REQ-017 Port: wb_mask  output  NUM_ELEMS  per-element write enables.
REQ-018 Port: busy  output  1  the sequencer is in a state other than IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, RUN and WB.
REQ-020 req_ready SHALL equal (state==IDLE && !kill).
REQ-021 Acceptance SHALL occur when req_valid && req_ready; on acceptance vl, src_b_sel and rd are latched.
REQ-022 A latched vl greater than NUM_ELEMS SHALL be clamped to NUM_ELEMS.
REQ-023 On acceptance with vl==0, the next state SHALL be WB with wb_mask=0 and no ALU issue.
REQ-024 On acceptance with vl>=1, the next state SHALL be RUN with the element counter at 0.
REQ-025 In RUN: alu_valid=1, alu_elem=counter, and alu_src_b_sel=the latched select.
REQ-026 In RUN, if alu_stall=1, the counter and alu_elem SHALL hold, alu_valid SHALL stay 1, and no element is consumed.
REQ-027 In RUN, if alu_stall=0, the element SHALL be consumed, its wb_mask bit set, and the counter incremented.
REQ-028 When the last element (counter==vl-1) is consumed, the next state SHALL be WB.
REQ-029 RUN latency SHALL be vl cycles plus the number of stall cycles, with no bubbles between elements.
REQ-030 The counter SHALL never wrap; at vl==NUM_ELEMS the last index is NUM_ELEMS-1, and the design then goes to WB.
REQ-031 WB SHALL last exactly one cycle: wb_valid=1, wb_rd=latched rd, wb_mask=accumulated mask; the next state is IDLE.
REQ-032 Outside WB, wb_valid SHALL be 0. Outside RUN, alu_valid SHALL be 0, alu_elem=0 and alu_src_b_sel=`SRC_B_RS2.
REQ-033 kill=1 in any state SHALL force IDLE next cycle, clear the mask, and suppress wb_valid in that cycle even in WB.
REQ-034 kill has priority over acceptance; no request is accepted in a kill cycle.
REQ-035 A new request SHALL NOT be accepted in the WB cycle; back-to-back ops are separated by one IDLE cycle.

Reset
REQ-036 While reset is high: state=IDLE, counter=0, mask=0, latched fields=0, and all outputs at their IDLE values.
REQ-037 IDLE output values: req_ready=1 (when kill=0), busy=0, alu_valid=0, wb_valid=0, wb_mask=0, alu_src_b_sel=`SRC_B_RS2.
REQ-038 Reset asserted mid-RUN or mid-WB SHALL abort the op immediately without a wb_valid pulse.

Structure
REQ-039 State encodings and SEQ_STATE_WIDTH SHALL be added to vscale_ctrl_constants.vh.
REQ-040 SRC_B_* and VEC_XPR_LEN SHALL be reused from the same header.
REQ-041 The block SHALL be a single module with no sub-modules; the src_b mux stays external, driven by alu_src_b_sel.

Verification
REQ-042 vl=4, sel=`SRC_B_IMM, rd=5, no stall -> alu_elem 0,1,2,3 on consecutive cycles with sel=IMM; WB next cycle, wb_rd=5, wb_mask=4'b1111.
REQ-043 vl=3, alu_stall high for 2 cycles at elem 1 -> elem 1 held for 3 cycles, RUN totals 5 cycles, wb_mask=4'b0111.
REQ-044 vl=0 -> no alu_valid; wb_valid one cycle after acceptance with wb_mask=0.
REQ-045 vl=9 -> clamped; 4 elements issued, wb_mask=4'b1111.
REQ-046 kill at elem 2 of vl=4 -> IDLE next cycle, no wb_valid, req_ready=1 next cycle.
REQ-047 Reset pulse during WB -> wb_valid drops in the same cycle (asynchronous), outputs at IDLE values.

Source files
------------

// File: rtl/xvec2_vscale_elem_seq_pkg.sv
// Shared constants for the vector element sequencer: operand-B select codes,
// sequencer state encodings and vector-length width.
package xvec2_vscale_elem_seq_pkg;

    localparam int SRC_B_SEL_WIDTH = 2;
    localparam logic [SRC_B_SEL_WIDTH-1:0] SRC_B_RS2  = 2'd0;
    localparam logic [SRC_B_SEL_WIDTH-1:0] SRC_B_IMM  = 2'd1;
    localparam logic [SRC_B_SEL_WIDTH-1:0] SRC_B_FOUR = 2'd2;
    localparam logic [SRC_B_SEL_WIDTH-1:0] SRC_B_ZERO = 2'd3;

    localparam int VEC_XPR_LEN     = 32;
    localparam int VL_W            = 4;
    localparam int SEQ_STATE_WIDTH = 2;

    typedef enum logic [SEQ_STATE_WIDTH-1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_WB   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/xvec2_vscale_elem_seq.sv
// Element sequencer: issues one vector element per cycle to a single ALU lane,
// accumulates a write mask, then emits a one-cycle write-back strobe.
module xvec2_vscale_elem_seq
    import xvec2_vscale_elem_seq_pkg::*;
#(
    parameter int NUM_ELEMS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [VL_W-1:0]            req_vl,
    input  logic [SRC_B_SEL_WIDTH-1:0] req_src_b_sel,
    input  logic [4:0]                 req_rd,
    output logic                       alu_valid,
    output logic [IDX_W-1:0]           alu_elem,
    output logic [SRC_B_SEL_WIDTH-1:0] alu_src_b_sel,
    input  logic                       alu_stall,
    input  logic                       kill,
    output logic                       wb_valid,
    output logic [4:0]                 wb_rd,
    output logic [NUM_ELEMS-1:0]       wb_mask,
    output logic                       busy
);

    seq_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           cnt_q, cnt_d;
    logic [NUM_ELEMS-1:0]       mask_q, mask_d;
    logic [VL_W-1:0]            vl_q, vl_d;
    logic [SRC_B_SEL_WIDTH-1:0] sel_q, sel_d;
    logic [4:0]                 rd_q, rd_d;

    logic [VL_W-1:0] vl_clamped;
    logic            last_elem;

    assign vl_clamped = (req_vl > VL_W'(NUM_ELEMS)) ? VL_W'(NUM_ELEMS) : req_vl;
    // Compare in the wider vl domain so NUM_ELEMS itself is reachable without wrap.
    assign last_elem  = (VL_W'(cnt_q) + VL_W'(1)) == vl_q;
    assign busy       = (state_q != SEQ_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            vl_q    <= '0;
            sel_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            vl_q    <= vl_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mask_d        = mask_q;
        vl_d          = vl_q;
        sel_d         = sel_q;
        rd_d          = rd_q;
        req_ready     = (state_q == SEQ_IDLE) && !kill;
        alu_valid     = 1'b0;
        alu_elem      = '0;
        alu_src_b_sel = SRC_B_RS2;
        wb_valid      = 1'b0;
        wb_rd         = '0;
        wb_mask       = '0;

        case (state_q)
            SEQ_IDLE: begin
                if (req_valid && req_ready) begin
                    vl_d    = vl_clamped;
                    sel_d   = req_src_b_sel;
                    rd_d    = req_rd;
                    cnt_d   = '0;
                    mask_d  = '0;
                    state_d = (vl_clamped == '0) ? SEQ_WB : SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                alu_valid     = 1'b1;
                alu_elem      = cnt_q;
                alu_src_b_sel = sel_q;
                if (!alu_stall) begin
                    mask_d[cnt_q] = 1'b1;
                    if (last_elem) begin
                        cnt_d   = '0;
                        state_d = SEQ_WB;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            SEQ_WB: begin
                wb_valid = !kill;
                wb_rd    = kill ? '0 : rd_q;
                wb_mask  = kill ? '0 : mask_q;
                state_d  = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase

        if (kill) begin
            state_d = SEQ_IDLE;
            cnt_d   = '0;
            mask_d  = '0;
        end
    end

endmodule

// File: tb/tb_xvec2_vscale_elem_seq.sv
// Randomized self-checking bench for the element sequencer against a
// cycle-level reference model of issue, stall, kill and write-back behaviour.
module tb_xvec2_vscale_elem_seq;
    import xvec2_vscale_elem_seq_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int OW = 3 + IW + SRC_B_SEL_WIDTH + 1 + 5 + N;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       req_valid;
    logic                       req_ready;
    logic [VL_W-1:0]            req_vl;
    logic [SRC_B_SEL_WIDTH-1:0] req_src_b_sel;
    logic [4:0]                 req_rd;
    logic                       alu_valid;
    logic [IW-1:0]              alu_elem;
    logic [SRC_B_SEL_WIDTH-1:0] alu_src_b_sel;
    logic                       alu_stall;
    logic                       kill;
    logic                       wb_valid;
    logic [4:0]                 wb_rd;
    logic [N-1:0]               wb_mask;
    logic                       busy;

    int checks = 0;
    int fails  = 0;

    logic [OW-1:0] obs_q [64];
    logic [OW-1:0] exp_q [64];

    xvec2_vscale_elem_seq #(.NUM_ELEMS(N), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_vl(req_vl),
        .req_src_b_sel(req_src_b_sel), .req_rd(req_rd),
        .alu_valid(alu_valid), .alu_elem(alu_elem), .alu_src_b_sel(alu_src_b_sel),
        .alu_stall(alu_stall), .kill(kill),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_mask(wb_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] pk(input logic rdy, input logic bsy, input logic av,
                                         input int el, input logic [1:0] sl, input logic wv,
                                         input logic [4:0] wr, input logic [N-1:0] wm);
        return {rdy, bsy, av, IW'(el), sl, wv, wr, wm};
    endfunction

    function automatic logic [OW-1:0] obs_now();
        return {req_ready, busy, alu_valid, alu_elem, alu_src_b_sel, wb_valid, wb_rd, wb_mask};
    endfunction

    // Expected per-cycle view of one op: cycle 0 is acceptance, then one
    // issue per cycle (repeated while stalled), one WB cycle, one idle cycle.
    task automatic build_exp(input int vl, input logic [1:0] sel, input logic [4:0] rd,
                             input logic [63:0] stall, input int kill_c, output int last);
        int eff = (vl > N) ? N : vl;
        int c = 1;
        int k = 0;
        exp_q[0] = pk(1, 0, 0, 0, SRC_B_RS2, 0, 0, 0);
        while (k < eff) begin
            exp_q[c] = pk(0, 1, 1, k, sel, 0, 0, 0);
            if (kill_c == c) begin
                last = c + 1;
                exp_q[last] = pk(1, 0, 0, 0, SRC_B_RS2, 0, 0, 0);
                return;
            end
            if (!(c < 64 && stall[c])) k++;
            c++;
        end
        if (kill_c == c) exp_q[c] = pk(0, 1, 0, 0, SRC_B_RS2, 0, 0, 0);
        else             exp_q[c] = pk(0, 1, 0, 0, SRC_B_RS2, 1, rd, N'((1 << eff) - 1));
        last = c + 1;
        exp_q[last] = pk(kill_c != last, 0, 0, 0, SRC_B_RS2, 0, 0, 0);
    endtask

    task automatic do_op(input logic [3:0] vl, input logic [1:0] sel, input logic [4:0] rd,
                         input logic [63:0] stall, input int kill_c, input int last);
        @(posedge clk); #1;
        req_valid = 1'b1; req_vl = vl; req_src_b_sel = sel; req_rd = rd;
        alu_stall = 1'b0; kill = 1'b0;
        #1 obs_q[0] = obs_now();
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; req_vl = '0; req_src_b_sel = '0; req_rd = '0;
            alu_stall = (c < 64) ? stall[c] : 1'b0;
            kill = (c == kill_c);
            #1 obs_q[c] = obs_now();
        end
        alu_stall = 1'b0; kill = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs_now() !== pk(1, 0, 0, 0, SRC_B_RS2, 0, 0, 0)) begin
            fails++; $display("FAIL reset_hold got=%h exp=%h", obs_now(), pk(1, 0, 0, 0, SRC_B_RS2, 0, 0, 0));
        end
        req_valid = 1'b1; req_vl = 4'd2;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || alu_valid !== 1'b0) begin
            fails++; $display("FAIL reset_ignores_req got busy=%b av=%b exp 0 0", busy, alu_valid);
        end
        req_valid = 1'b0; req_vl = '0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_full();
        int last;
        build_exp(4, SRC_B_IMM, 5'd5, 64'h0, -1, last);
        do_op(4'd4, SRC_B_IMM, 5'd5, 64'h0, -1, last);
        for (int c = 0; c <= last; c++) begin
            checks++;
            if (obs_q[c] !== exp_q[c]) begin fails++; $display("FAIL full_vl4 cyc=%0d got=%h exp=%h", c, obs_q[c], exp_q[c]); end
        end
    endtask

    task automatic test_stall();
        int last;
        int runs = 0;
        build_exp(3, SRC_B_RS2, 5'd11, 64'hC, -1, last);
        do_op(4'd3, SRC_B_RS2, 5'd11, 64'hC, -1, last);
        for (int c = 0; c <= last; c++) begin
            checks++;
            if (obs_q[c] !== exp_q[c]) begin fails++; $display("FAIL stall_vl3 cyc=%0d got=%h exp=%h", c, obs_q[c], exp_q[c]); end
            if (obs_q[c][OW-3]) runs++;
        end
        checks++;
        if (runs !== 5) begin fails++; $display("FAIL stall_run_len got=%0d exp=5", runs); end
    endtask

    task automatic test_vl0();
        int last;
        build_exp(0, SRC_B_FOUR, 5'd9, 64'h0, -1, last);
        do_op(4'd0, SRC_B_FOUR, 5'd9, 64'h0, -1, last);
        for (int c = 0; c <= last; c++) begin
            checks++;
            if (obs_q[c] !== exp_q[c]) begin fails++; $display("FAIL vl0 cyc=%0d got=%h exp=%h", c, obs_q[c], exp_q[c]); end
        end
    endtask

    task automatic test_clamp();
        int last;
        for (int v = 9; v <= 15; v += 6) begin
            build_exp(v, SRC_B_ZERO, 5'd17, 64'h0, -1, last);
            do_op(4'(v), SRC_B_ZERO, 5'd17, 64'h0, -1, last);
            for (int c = 0; c <= last; c++) begin
                checks++;
                if (obs_q[c] !== exp_q[c]) begin fails++; $display("FAIL clamp vl=%0d cyc=%0d got=%h exp=%h", v, c, obs_q[c], exp_q[c]); end
            end
        end
    endtask

    task automatic test_kill();
        int last;
        build_exp(4, SRC_B_IMM, 5'd21, 64'h0, 3, last);
        do_op(4'd4, SRC_B_IMM, 5'd21, 64'h0, 3, last);
        for (int c = 0; c <= last; c++) begin
            checks++;
            if (obs_q[c] !== exp_q[c]) begin fails++; $display("FAIL kill_elem2 cyc=%0d got=%h exp=%h", c, obs_q[c], exp_q[c]); end
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_vl = 4'd2; kill = 1'b1;
        #1 checks++;
        if (req_ready !== 1'b0) begin fails++; $display("FAIL kill_blocks_ready got=%b exp=0", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0; req_vl = '0; kill = 1'b0;
        #1 checks++;
        if (busy !== 1'b0 || alu_valid !== 1'b0) begin
            fails++; $display("FAIL kill_blocks_accept got busy=%b av=%b exp 0 0", busy, alu_valid);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        req_valid = 1'b1; req_vl = 4'd1; req_src_b_sel = SRC_B_FOUR; req_rd = 5'd3;
        #1 checks++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_accept_a got=%b exp=1", req_ready); end
        @(posedge clk); #1; req_valid = 1'b0;
        #1 checks++;
        if (obs_now() !== pk(0, 1, 1, 0, SRC_B_FOUR, 0, 0, 0)) begin fails++; $display("FAIL b2b_run_a got=%h", obs_now()); end
        @(posedge clk); #1;
        req_valid = 1'b1; req_vl = 4'd2; req_src_b_sel = SRC_B_ZERO; req_rd = 5'd7;
        #1 checks++;
        if (obs_now() !== pk(0, 1, 0, 0, SRC_B_RS2, 1, 5'd3, 4'b0001)) begin fails++; $display("FAIL b2b_wb_a got=%h", obs_now()); end
        @(posedge clk); #1;
        #1 checks++;
        if (obs_now() !== pk(1, 0, 0, 0, SRC_B_RS2, 0, 0, 0)) begin fails++; $display("FAIL b2b_idle_gap got=%h", obs_now()); end
        for (int e = 0; e < 2; e++) begin
            @(posedge clk); #1; req_valid = 1'b0;
            #1 checks++;
            if (obs_now() !== pk(0, 1, 1, e, SRC_B_ZERO, 0, 0, 0)) begin fails++; $display("FAIL b2b_run_b e=%0d got=%h", e, obs_now()); end
        end
        @(posedge clk); #2 checks++;
        if (obs_now() !== pk(0, 1, 0, 0, SRC_B_RS2, 1, 5'd7, 4'b0011)) begin fails++; $display("FAIL b2b_wb_b got=%h", obs_now()); end
        req_vl = '0; req_src_b_sel = '0; req_rd = '0;
        @(posedge clk);
    endtask

    task automatic test_reset_wb();
        @(posedge clk); #1;
        req_valid = 1'b1; req_vl = 4'd1; req_src_b_sel = SRC_B_IMM; req_rd = 5'd30;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #2 checks++;
        if (obs_now() !== pk(0, 1, 0, 0, SRC_B_RS2, 1, 5'd30, 4'b0001)) begin fails++; $display("FAIL rstwb_pre got=%h", obs_now()); end
        reset = 1'b1;
        #1 checks++;
        if (obs_now() !== pk(1, 0, 0, 0, SRC_B_RS2, 0, 0, 0)) begin fails++; $display("FAIL rstwb_async got=%h", obs_now()); end
        @(negedge clk); reset = 1'b0;
        req_vl = '0; req_src_b_sel = '0; req_rd = '0;
    endtask

    task automatic test_random();
        int last, vl, kc;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [63:0] st;
        for (int i = 0; i < 40; i++) begin
            vl  = $urandom_range(0, 15);
            sel = 2'($urandom_range(0, 3));
            rd  = 5'($urandom);
            st  = '0;
            for (int b = 1; b < 40; b++) st[b] = ($urandom_range(0, 9) < 3);
            kc  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : -1;
            build_exp(vl, sel, rd, st, kc, last);
            do_op(4'(vl), sel, rd, st, kc, last);
            for (int c = 0; c <= last; c++) begin
                checks++;
                if (obs_q[c] !== exp_q[c]) begin
                    fails++; $display("FAIL random op=%0d vl=%0d kill=%0d cyc=%0d got=%h exp=%h", i, vl, kc, c, obs_q[c], exp_q[c]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_vl = '0; req_src_b_sel = '0; req_rd = '0;
        alu_stall = 1'b0; kill = 1'b0;
        test_reset();
        test_full();
        test_stall();
        test_vl0();
        test_clamp();
        test_kill();
        test_back_to_back();
        test_reset_wb();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
